// File: rtl/sequence_match_controller.sv
// Run-time programmable serial pattern matcher: compares the last len accepted bits
// against a loaded pattern and counts matches until an optional threshold is reached.
module sequence_match_controller #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   threshold,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               in_ready,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0] MaxLenC = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] OneLenC = LEN_W'(1);
    localparam logic [CNT_W-1:0] CntMaxC = '1;

    state_e state_q, state_d;

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               det_q, det_d;

    logic [LEN_W-1:0]   lenClamped;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] lenMask;
    logic [LEN_W-1:0]   fillInc;
    logic [CNT_W-1:0]   countInc;
    logic               accept;
    logic               isMatch;
    logic               hitThreshold;
    logic               startGo;

    // The newest bit is not yet in the history, so the window is history plus in_bit.
    always_comb begin
        if (cfg_len == '0) begin
            lenClamped = OneLenC;
        end else if (cfg_len > MaxLenC) begin
            lenClamped = MaxLenC;
        end else begin
            lenClamped = cfg_len;
        end

        window       = {hist_q, in_bit};
        lenMask      = ~({MAX_LEN{1'b1}} << len_q);
        fillInc      = (fill_q < len_q) ? fill_q + OneLenC : fill_q;
        countInc     = (count_q == CntMaxC) ? count_q : count_q + CNT_W'(1);
        accept       = in_valid & in_ready;
        isMatch      = accept && (fillInc == len_q) && (((window ^ pattern_q) & lenMask) == '0);
        hitThreshold = isMatch && (threshold != '0) && (countInc == threshold);
        startGo      = start & ~stop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) state_d = StRun;
                end
                StRun: begin
                    if (start) begin
                        state_d = StRun;
                    end else if (hitThreshold) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (start) state_d = StRun;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready    = (state_q == StRun) & ~start & ~stop;
        busy        = (state_q == StRun);
        done        = (state_q == StDone);
        detected    = det_q;
        match_count = count_q;
    end

    // A start (without stop) wipes the run; otherwise only accepted bits move the datapath.
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        count_d   = count_q;
        det_d     = isMatch;

        if ((state_q == StIdle) && cfg_we) begin
            pattern_d = cfg_pattern;
            len_d     = lenClamped;
            overlap_d = cfg_overlap;
        end

        if (startGo) begin
            hist_d  = '0;
            fill_d  = '0;
            count_d = '0;
        end else if (accept) begin
            hist_d = window[MAX_LEN-2:0];
            fill_d = (isMatch && !overlap_q) ? '0 : fillInc;
            if (isMatch) begin
                count_d = countInc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q <= '0;
            len_q     <= MaxLenC;
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            det_q     <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            det_q     <= det_d;
        end
    end

endmodule

// File: doc/sequence_match_controller.md
# sequence_match_controller

Run-time configurable serial pattern matcher with its own controller. Software loads a pattern of up to MAX_LEN bits, arms the block, streams bits through a valid/ready handshake, and reads a saturating match count. The block stops accepting bits once a programmed match threshold is reached. It sits in front of a serial bit source and replaces fixed-pattern detector FSMs, so one instance serves any pattern without an RTL change.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2)
- CNT_W, 8: width of the match counter and threshold
- LEN_W, $clog2(MAX_LEN)+1: width of cfg_len (derived)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  load configuration; honoured only in IDLE
- cfg_pattern  in  MAX_LEN  pattern; first-received bit is cfg_pattern[len-1], last is [0]
- cfg_len  in  LEN_W  pattern length; 0 is treated as 1, >MAX_LEN as MAX_LEN
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history restarts after a match
- threshold  in  CNT_W  match count that ends the run; 0 = never ends
- start  in  1  single-cycle pulse: clear count/history and enter RUN
- stop  in  1  single-cycle pulse: return to IDLE
- in_valid  in  1  serial bit valid
- in_bit  in  1  serial data bit
- in_ready  out  1  bit accepted when in_valid & in_ready
- detected  out  1  one-cycle pulse per match
- match_count  out  CNT_W  saturating match count
- busy  out  1  state == RUN
- done  out  1  state == DONE

## Operation
- Three-state FSM: IDLE, RUN, DONE.
- IDLE:
  - cfg_we latches pattern, clamped length and overlap.
  - start → RUN, clearing history, fill and match_count.
- RUN:
  - Each accepted bit shifts into the history register at the LSB.
  - fill increments, saturating at len.
  - A match occurs when the post-shift fill == len and history[len-1:0] == pattern[len-1:0].
  - On a match: detected=1 for one cycle; match_count+1, saturating at 2^CNT_W−1.
  - If cfg_overlap=0, fill is cleared to 0 after a match.
  - If threshold≠0 and the post-increment count == threshold → DONE.
- DONE: done=1 and in_ready=0. match_count is held. start → RUN (full clear); stop → IDLE.
- stop in any state → IDLE. match_count is held, not cleared.
- start and stop in the same cycle: stop wins.
- start in RUN restarts the run: history, fill and count are cleared.
- in_ready = (state==RUN) & ~start & ~stop. A bit is never accepted in a cycle carrying start or stop.
- cfg_we outside IDLE is ignored. The configuration stays stable for the whole run.
- threshold is sampled live every match, not latched.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0.
  - pattern=0, len=MAX_LEN, overlap=1; history, fill and match_count = 0.
- in_ready is combinational from state, start and stop. The same cycle applies for acceptance.
- Latency: the bit accepted at edge k completes the match. detected and the new match_count are visible in the cycle after edge k. A DONE transition happens at the same edge k.
- detected is never high for two consecutive cycles unless two consecutive accepted bits both complete matches (overlap=1 with len=1, or a periodic pattern).
- in_valid=0 cycles: no shift and no state change. Gaps between bits are transparent.
- Counter saturation: at max, further matches still pulse detected, but the count does not wrap.
- Asserting reset mid-run aborts immediately. There is no partial-match carry-over after reset is released.

## Test plan
- Pattern 110011, len 6, overlap=1, threshold=0; stream 1100110011 → detected after bits 6 and 10; match_count=2; state stays RUN.
- Same pattern, overlap=0 → detected only after bit 6; match_count=1.
- Pattern 1010, len 4, threshold=2, overlap=1; stream 101010, with random in_valid gaps → matches after bits 4 and 6. DONE with done=1 and in_ready=0 at the same edge as the second match; later bits are not accepted.
- CNT_W=2, threshold=0, len=1, pattern 1; stream 5 ones → detected pulses 5 times; match_count saturates at 3.
- start and stop asserted together in RUN → IDLE; in_ready=0 that cycle; count held. cfg_we in RUN is ignored (verify by matching the old pattern after restart).
- rst=0 mid-stream after 5 of 6 pattern bits → all outputs 0 asynchronously. Reconfigure, restart and send the final bit alone → no detection.
